// File: rtl/pe_seq_pkg.sv
// Shared state encoding, default geometry and sizing helpers for the first-layer PE sequencer.
package pe_seq_pkg;

    localparam int K_DEF     = 3;
    localparam int IMG_W_DEF = 28;
    localparam int IMG_H_DEF = 28;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_MAC    = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_RESULT = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int taps_of(input int k);
        return k * k;
    endfunction

    function automatic int out_dim(input int img, input int k);
        return img - k + 1;
    endfunction

endpackage

// File: rtl/pe_seq_ctrl_1st_win_tap_cnt.sv
// Nested row/column counter (column inner) with enable, synchronous clear and wrap flag.
module win_tap_cnt #(
    parameter int N_R = 3,
    parameter int N_C = 3,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] r,
    output logic [W-1:0] c,
    output logic         wrap
);

    logic last;

    assign last = (r == W'(N_R - 1)) && (c == W'(N_C - 1));
    assign wrap = en && last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= '0;
            c <= '0;
        end else if (clr) begin
            r <= '0;
            c <= '0;
        end else if (en) begin
            if (c == W'(N_C - 1)) begin
                c <= '0;
                r <= (r == W'(N_R - 1)) ? '0 : r + W'(1);
            end else begin
                c <= c + W'(1);
            end
        end
    end

endmodule

// File: rtl/pe_seq_ctrl_1st.sv
// First-layer conv PE sequencer: walks the KxK window per output pixel and drives PE en/flush.
// Optional build macro PE_SEQ_CTRL_PERF_EN adds the stall_cnt_o result-stall counter.
//
// state  | meaning
// IDLE   | waiting for start_i
// CLEAR  | flush stale accumulator, issue first tap
// MAC    | one kernel tap address per cycle
// DRAIN  | last buffer read lands in the PE
// RESULT | sum valid, waiting on res_ready_i
// DONE   | one-cycle completion pulse
module pe_seq_ctrl_1st
    import pe_seq_pkg::*;
#(
    parameter int K       = K_DEF,
    parameter int IMG_W   = IMG_W_DEF,
    parameter int IMG_H   = IMG_H_DEF,
    parameter int ADDR_W  = 10,
    parameter int WADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               res_ready_i,
    output logic [ADDR_W-1:0]  pix_addr_o,
    output logic [WADDR_W-1:0] wgt_addr_o,
    output logic               pe_en_o,
    output logic               pe_flush_o,
    output logic               res_valid_o,
    output logic [ADDR_W-1:0]  out_row_o,
    output logic [ADDR_W-1:0]  out_col_o,
    output logic               busy_o,
    output logic               done_o
`ifdef PE_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]        stall_cnt_o
`endif
);

    localparam int TAPS  = taps_of(K);
    localparam int OUT_W = out_dim(IMG_W, K);
    localparam int OUT_H = out_dim(IMG_H, K);
    localparam int KW    = width_of(K);

    logic [2:0]        state, state_nxt;
    logic [KW-1:0]     kr, kc;
    logic              tap_wrap;
    logic [ADDR_W-1:0] pr, pc;
    logic              pix_wrap;
    logic              last_tap_q;
    logic              last_pix_q;
    logic              flush_q;
    logic              start_acc;
    logic              accept;
    logic              issue;
    logic [ADDR_W-1:0] pix_calc;
    logic [WADDR_W-1:0] wgt_calc;

    assign start_acc = (state == ST_IDLE) && start_i;
    assign accept    = (state == ST_RESULT) && res_ready_i;

    // The pixel counter advances in DRAIN, so on accept it already points at the next pixel.
    assign issue = (state == ST_CLEAR)
                || ((state == ST_MAC) && !last_tap_q)
                || (accept && !last_pix_q);

    win_tap_cnt #(.N_R(K), .N_C(K), .W(KW)) u_tap_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (issue),
        .clr  (start_acc),
        .r    (kr),
        .c    (kc),
        .wrap (tap_wrap)
    );

    win_tap_cnt #(.N_R(OUT_H), .N_C(OUT_W), .W(ADDR_W)) u_pix_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (state == ST_DRAIN),
        .clr  (start_acc),
        .r    (pr),
        .c    (pc),
        .wrap (pix_wrap)
    );

    assign pix_calc = ADDR_W'((32'(pr) + 32'(kr)) * 32'(IMG_W) + 32'(pc) + 32'(kc));
    assign wgt_calc = WADDR_W'(32'(kr) * 32'(K) + 32'(kc));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start_i) state_nxt = ST_CLEAR;
            ST_CLEAR:  state_nxt = ST_MAC;
            ST_MAC:    if (last_tap_q) state_nxt = ST_DRAIN;
            ST_DRAIN:  state_nxt = ST_RESULT;
            ST_RESULT: if (res_ready_i) state_nxt = last_pix_q ? ST_DONE : ST_MAC;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            last_tap_q  <= 1'b0;
            last_pix_q  <= 1'b0;
            flush_q     <= 1'b0;
            pix_addr_o  <= '0;
            wgt_addr_o  <= '0;
            pe_en_o     <= 1'b0;
            res_valid_o <= 1'b0;
            out_row_o   <= '0;
            out_col_o   <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            state       <= state_nxt;
            flush_q     <= (state_nxt == ST_CLEAR);
            pe_en_o     <= (state == ST_MAC);
            res_valid_o <= (state_nxt == ST_RESULT);
            busy_o      <= (state_nxt != ST_IDLE);
            done_o      <= (state_nxt == ST_DONE);
            if (start_acc) begin
                last_pix_q <= 1'b0;
            end else if (state == ST_DRAIN) begin
                last_pix_q <= pix_wrap;
                out_row_o  <= pr;
                out_col_o  <= pc;
            end
            if (issue) begin
                pix_addr_o <= pix_calc;
                wgt_addr_o <= wgt_calc;
                last_tap_q <= tap_wrap;
            end
        end
    end

    // Flush on accept must land on the same edge the sum is captured downstream.
    assign pe_flush_o = flush_q | (res_valid_o & res_ready_i);

`ifdef PE_SEQ_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_o <= '0;
        end else if (start_acc) begin
            stall_cnt_o <= '0;
        end else if ((state == ST_RESULT) && !res_ready_i && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_seq_ctrl_1st.sv
// Scoreboard bench for pe_seq_ctrl_1st on a 5x5 image with a 3x3 kernel.
module tb_pe_seq_ctrl_1st;

    localparam int K    = 3;
    localparam int IW   = 5;
    localparam int IH   = 5;
    localparam int AW   = 10;
    localparam int WW   = 4;
    localparam int OW   = IW - K + 1;
    localparam int OH   = IH - K + 1;
    localparam int TAPS = K * K;
    localparam int PASS_CYC = 1 + OW * OH * (TAPS + 2);

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic          res_ready_i;
    logic [AW-1:0] pix_addr_o;
    logic [WW-1:0] wgt_addr_o;
    logic          pe_en_o;
    logic          pe_flush_o;
    logic          res_valid_o;
    logic [AW-1:0] out_row_o;
    logic [AW-1:0] out_col_o;
    logic          busy_o;
    logic          done_o;
`ifdef PE_SEQ_CTRL_PERF_EN
    logic [31:0]   stall_cnt_o;
`endif

    pe_seq_ctrl_1st #(.K(K), .IMG_W(IW), .IMG_H(IH), .ADDR_W(AW), .WADDR_W(WW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .res_ready_i (res_ready_i),
        .pix_addr_o  (pix_addr_o),
        .wgt_addr_o  (wgt_addr_o),
        .pe_en_o     (pe_en_o),
        .pe_flush_o  (pe_flush_o),
        .res_valid_o (res_valid_o),
        .out_row_o   (out_row_o),
        .out_col_o   (out_col_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
`ifdef PE_SEQ_CTRL_PERF_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int res_q[$];
    int addr_q[$];
    int done_seen = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Reference: raster order of output pixels, each with its KxK taps (column inner).
    function automatic void push_pass();
        for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++) begin
                res_q.push_back(r * 256 + c);
                for (int kr = 0; kr < K; kr++)
                    for (int kc = 0; kc < K; kc++)
                        addr_q.push_back(((r + kr) * IW + c + kc) * 16 + kr * K + kc);
            end
    endfunction

    // Monitor
    int cyc = 0, clear_cyc = 0, en_cnt = 0, stalls = 0, prev_pix = 0, prev_wgt = 0;
    bit busy_prev = 0, first_res = 0;

    always @(negedge clk) begin
        if (rst) begin
            busy_prev = 0;
            en_cnt    = 0;
            cyc       = 0;
        end else begin
            cyc++;
            if (busy_o && !busy_prev) begin
                clear_cyc = cyc;
                first_res = 1;
                stalls    = 0;
                en_cnt    = 0;
                check("clear_flush", pe_flush_o, 1);
            end
            if (busy_o) check("en_flush_excl", pe_en_o & pe_flush_o, 0);
            if (pe_en_o) begin
                en_cnt++;
                if (addr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tap_extra: pe_en high with no tap expected at cycle %0d", cyc);
                end else begin
                    int e;
                    e = addr_q.pop_front();
                    check("pix_addr", prev_pix, e / 16);
                    check("wgt_addr", prev_wgt, e % 16);
                end
            end
            if (res_valid_o) begin
                if (first_res) begin
                    check("first_res_lat", cyc - clear_cyc, TAPS + 2);
                    first_res = 0;
                end
                check("res_en_low", pe_en_o, 0);
                if (res_ready_i) begin
                    check("accept_flush", pe_flush_o, 1);
                    check("en_per_res", en_cnt, TAPS);
                    en_cnt = 0;
                    if (res_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL res_extra: row %0d col %0d not expected", out_row_o, out_col_o);
                    end else begin
                        int e;
                        e = res_q.pop_front();
                        check("res_coord", {out_row_o, out_col_o}, {AW'(e / 256), AW'(e % 256)});
                    end
                end else begin
                    check("stall_flush", pe_flush_o, 0);
                    stalls++;
                end
            end
            if (done_o) begin
                done_seen++;
                check("done_lat", cyc - clear_cyc, PASS_CYC + stalls);
                check("res_left", res_q.size(), 0);
                check("tap_left", addr_q.size(), 0);
`ifdef PE_SEQ_CTRL_PERF_EN
                check("stall_cnt", stall_cnt_o, stalls);
`endif
            end
            prev_pix  = int'(pix_addr_o);
            prev_wgt  = int'(wgt_addr_o);
            busy_prev = busy_o;
        end
    end

    // mode 0: always ready; 1: five-cycle stall at pixel (0,1); 2: random ready
    task automatic run_pass(input int mode, input bit noise);
        int stall_left;
        bit got;
        stall_left = 5;
        got = 0;
        push_pass();
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (done_o) begin
                start_i     = 1'b0;
                res_ready_i = 1'b1;
                got = 1;
                break;
            end
            if (mode == 1) begin
                if (res_valid_o && out_row_o == 0 && out_col_o == 1 && stall_left > 0) begin
                    res_ready_i = 1'b0;
                    stall_left--;
                end else begin
                    res_ready_i = 1'b1;
                end
            end else if (mode == 2) begin
                res_ready_i = ($urandom_range(0, 2) != 0);
            end else begin
                res_ready_i = 1'b1;
            end
            if (noise) start_i = busy_o && ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL pass_timeout: done_o not seen, mode %0d", mode);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst         = 1'b1;
        start_i     = 1'b0;
        res_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_state", {pix_addr_o, wgt_addr_o, pe_en_o, pe_flush_o, res_valid_o,
                              out_row_o, out_col_o, busy_o, done_o}, 0);

        // reset during the 4th MAC cycle
        @(posedge clk); #1;
        push_pass();
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        res_q.delete();
        addr_q.delete();
        #1;
        check("rst_mid_mac", {pix_addr_o, wgt_addr_o, pe_en_o, pe_flush_o, res_valid_o,
                              out_row_o, out_col_o, busy_o, done_o}, 0);
        @(posedge clk); #1;
        check("rst_no_done", done_seen, 0);
        rst = 1'b0;

        run_pass(0, 1'b0);
        run_pass(1, 1'b0);
        run_pass(2, 1'b1);
        run_pass(0, 1'b0);
        check("done_count", done_seen, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
